// File: rtl/accel_output_sequencer.sv
// accel_output_sequencer
// Walks a block of result words out of the result RAM and hands them one at a
// time to the output decoder. Each word is clamped to 9999, waits for the UART
// to be idle, is strobed for one cycle and then followed by a fixed idle gap so
// the decoder always completes its print burst before the next word arrives.
module accel_output_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18,
  parameter int GAP    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              tx_idle,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WAIT_TX = 3'd3,
    S_ISSUE   = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  // Last value of the gap counter; the counter runs 0..GAP-1 while in S_GAP.
  localparam logic [7:0]        GAP_LAST = 8'(GAP - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = DATA_W'(14'd9999);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // True when a RAM word cannot be shown as four decimal digits.
  function automatic logic over_range(input logic [DATA_W-1:0] w);
    return (w > SAT_MAX);
  endfunction

  // Limit a RAM word to the largest four-digit decimal value.
  function automatic logic [DATA_W-1:0] clamp_word(input logic [DATA_W-1:0] w);
    return over_range(w) ? SAT_MAX : w;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          gap_q, gap_d;
  logic                sat_q, sat_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                read_valid_q, read_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic and datapath updates; outputs are derived from the next
  // state so every output register lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    gap_d   = gap_q;
    sat_d   = sat_q;

    if (abort) begin
      // Abort ends any run and also swallows a simultaneous start in idle.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d  = base_addr;
            rem_d   = count;
            sat_d   = 1'b0;
            state_d = (count == ADDR_ZERO) ? S_DONE : S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          word_d = clamp_word(mem_data);
          if (over_range(mem_data)) begin
            sat_d = 1'b1;
          end else begin
            sat_d = sat_q;
          end
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - ADDR_ONE;
          state_d = S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_idle) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_WAIT_TX;
          end
        end
        S_ISSUE: begin
          gap_d   = 8'd0;
          state_d = S_GAP;
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = (rem_q == ADDR_ZERO) ? S_DONE : S_FETCH;
          end else begin
            gap_d   = gap_q + 8'd1;
            state_d = S_GAP;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    mem_en_d     = (state_d == S_FETCH);
    mem_addr_d   = mem_en_d ? addr_d : mem_addr_q;
    read_valid_d = (state_d == S_ISSUE);
    read_data_d  = read_valid_d ? word_d : read_data_q;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= ADDR_ZERO;
      rem_q        <= ADDR_ZERO;
      word_q       <= {DATA_W{1'b0}};
      gap_q        <= 8'd0;
      sat_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= ADDR_ZERO;
      read_data_q  <= {DATA_W{1'b0}};
      read_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      word_q       <= word_d;
      gap_q        <= gap_d;
      sat_q        <= sat_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_accel_output_sequencer.sv
// Bench for accel_output_sequencer: an event-schedule reference model (absolute
// cycle numbers for fetch, issue and done) checked every cycle, plus directed
// scenarios with hand-computed cycle/data expectations and a randomized phase.
module tb_accel_output_sequencer;
  localparam int AW  = 10;
  localparam int DW  = 18;
  localparam int GP  = 6;
  localparam int NEG = -100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, tx_idle = 1'b1;
  logic [AW-1:0] base_addr = '0, count = '0;
  logic          mem_en, read_valid, busy, done, sat;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0, read_data;

  accel_output_sequencer #(.ADDR_W(AW), .DATA_W(DW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_idle(tx_idle), .read_data(read_data), .read_valid(read_valid),
    .busy(busy), .done(done), .sat(sat)
  );

  initial forever #5 clk = ~clk;

  // Result RAM: synchronous read, data one cycle after mem_en.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) if (mem_en) mem_data <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (event schedule) ----------------
  bit            m_run = 0, m_sat = 0;
  int            fetch_at = NEG, issue_at = NEG, done_at = NEG, wait_from = NEG;
  int            m_addr = 0, m_left = 0;
  logic [DW-1:0] m_word = '0;
  logic          e_mem_en = 0, e_rv = 0, e_busy = 0, e_done = 0, e_sat = 0;
  logic [AW-1:0] e_mem_addr = '0;
  logic [DW-1:0] e_rd = '0;

  initial forever begin
    int p, n;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_run = 0; m_sat = 0; e_mem_addr = '0; e_rd = '0;
      e_mem_en = 0; e_rv = 0; e_busy = 0; e_done = 0; e_sat = 0;
    end else begin
      p = cyc; n = p + 1;
      if (m_run) begin
        if (abort) m_run = 0;
        else if (p == done_at) m_run = 0;
        else if (p == fetch_at + 1) begin
          m_word = (ram[m_addr] > 18'd9999) ? 18'd9999 : ram[m_addr];
          if (ram[m_addr] > 18'd9999) m_sat = 1;
          m_addr = (m_addr + 1) % 1024;
          m_left = m_left - 1;
          wait_from = p + 1;
        end else if (wait_from >= 0 && p >= wait_from && tx_idle) begin
          issue_at = p + 1;
          wait_from = NEG;
          if (m_left == 0) done_at = issue_at + GP + 1;
          else fetch_at = issue_at + GP + 1;
        end
      end else if (start && !abort) begin
        m_run = 1; m_sat = 0;
        m_addr = int'(base_addr); m_left = int'(count);
        issue_at = NEG; wait_from = NEG;
        if (count == 0) begin done_at = n; fetch_at = NEG; end
        else begin fetch_at = n; done_at = NEG; end
      end
      e_busy   = m_run;
      e_mem_en = m_run && (n == fetch_at);
      if (e_mem_en) e_mem_addr = AW'(m_addr);
      e_rv     = m_run && (n == issue_at);
      if (e_rv) e_rd = m_word;
      e_done   = m_run && (n == done_at);
      e_sat    = m_sat;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int            c0 = 0, last_busy = NEG;
  int            rv_cyc[$], me_adr[$], dn_cyc[$];
  logic [DW-1:0] rv_dat[$];

  initial forever begin
    @(negedge clk);
    chk("mem_en", 32'(mem_en), 32'(e_mem_en));
    chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    chk("read_valid", 32'(read_valid), 32'(e_rv));
    chk("read_data", 32'(read_data), 32'(e_rd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("sat", 32'(sat), 32'(e_sat));
    if (read_valid) begin rv_cyc.push_back(cyc - c0); rv_dat.push_back(read_data); end
    if (mem_en) me_adr.push_back(int'(mem_addr));
    if (done) dn_cyc.push_back(cyc - c0);
    if (busy) last_busy = cyc - c0;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rv_cyc.delete(); rv_dat.delete(); me_adr.delete(); dn_cyc.delete(); last_busy = NEG;
  endtask

  task automatic do_start(input int b, input int c);
    base_addr = AW'(b); count = AW'(c); start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy; k++) tick();
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_rv3(input string tag, input int a, input int b, input int c,
                         input int da, input int db, input int dc);
    chk({tag, "_rv_n"}, 32'(rv_cyc.size()), 32'd3);
    if (rv_cyc.size() == 3) begin
      chk({tag, "_rv0_cyc"}, 32'(rv_cyc[0]), 32'(a));
      chk({tag, "_rv1_cyc"}, 32'(rv_cyc[1]), 32'(b));
      chk({tag, "_rv2_cyc"}, 32'(rv_cyc[2]), 32'(c));
      chk({tag, "_rv0_dat"}, 32'(rv_dat[0]), 32'(da));
      chk({tag, "_rv1_dat"}, 32'(rv_dat[1]), 32'(db));
      chk({tag, "_rv2_dat"}, 32'(rv_dat[2]), 32'(dc));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom_range(0, 262143));
    ram[5] = 18'd42; ram[6] = 18'd1234; ram[7] = 18'd9999; ram[0] = 18'd12000;

    #1 rst = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Normal run
    clear_logs(); do_start(5, 3); wait_idle();
    chk_rv3("norm", 4, 14, 24, 42, 1234, 9999);
    chk("norm_done_n", 32'(dn_cyc.size()), 32'd1);
    if (dn_cyc.size() == 1) chk("norm_done_cyc", 32'(dn_cyc[0]), 32'd31);
    chk("norm_last_busy", 32'(last_busy), 32'd31);
    chk("norm_sat", 32'(sat), 32'd0);

    // Saturation, then clear on next start
    clear_logs(); do_start(0, 1); wait_idle();
    chk("sat_rv_n", 32'(rv_dat.size()), 32'd1);
    if (rv_dat.size() == 1) begin
      chk("sat_rv_dat", 32'(rv_dat[0]), 32'd9999);
      chk("sat_rv_cyc", 32'(rv_cyc[0]), 32'd4);
    end
    chk("sat_flag", 32'(sat), 32'd1);
    clear_logs(); do_start(5, 1);
    chk("sat_cleared", 32'(sat), 32'd0);
    wait_idle();

    // Backpressure: tx_idle low for cycles 0..22
    clear_logs(); tx_idle = 1'b0; do_start(6, 1);
    repeat (22) tick();
    tx_idle = 1'b1;
    wait_idle();
    chk("bp_rv_n", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1) begin
      chk("bp_rv_cyc", 32'(rv_cyc[0]), 32'd24);
      chk("bp_rv_dat", 32'(rv_dat[0]), 32'd1234);
    end
    chk("bp_done_n", 32'(dn_cyc.size()), 32'd1);
    if (dn_cyc.size() == 1) chk("bp_done_cyc", 32'(dn_cyc[0]), 32'd31);

    // Address wrap
    clear_logs(); do_start(1023, 2); wait_idle();
    chk("wrap_me_n", 32'(me_adr.size()), 32'd2);
    if (me_adr.size() == 2) begin
      chk("wrap_addr0", 32'(me_adr[0]), 32'd1023);
      chk("wrap_addr1", 32'(me_adr[1]), 32'd0);
    end

    // Zero count
    clear_logs(); do_start(9, 0); wait_idle();
    chk("zero_me_n", 32'(me_adr.size()), 32'd0);
    chk("zero_rv_n", 32'(rv_cyc.size()), 32'd0);
    chk("zero_done_n", 32'(dn_cyc.size()), 32'd1);
    if (dn_cyc.size() == 1) chk("zero_done_cyc", 32'(dn_cyc[0]), 32'd1);
    chk("zero_last_busy", 32'(last_busy), 32'd1);

    // Abort during the second gap (cycles 15..20)
    clear_logs(); do_start(5, 4);
    repeat (15) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("abort_done_n", 32'(dn_cyc.size()), 32'd0);
    chk("abort_rv_n", 32'(rv_cyc.size()), 32'd2);

    // Reset mid-run, then a fresh run
    clear_logs(); do_start(5, 3);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_read_data", 32'(read_data), 32'd0);
    chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mrst_mem_en", 32'(mem_en), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_logs(); do_start(5, 3); wait_idle();
    chk_rv3("post_rst", 4, 14, 24, 42, 1234, 9999);

    // Start while busy is ignored
    clear_logs(); do_start(5, 3);
    repeat (5) tick();
    base_addr = 10'd100; count = 10'd7; start = 1'b1; tick(); start = 1'b0;
    wait_idle();
    chk_rv3("busy_start", 4, 14, 24, 42, 1234, 9999);
    chk("busy_start_me_n", 32'(me_adr.size()), 32'd3);
    if (me_adr.size() == 3) begin
      chk("busy_start_a0", 32'(me_adr[0]), 32'd5);
      chk("busy_start_a2", 32'(me_adr[2]), 32'd7);
    end

    // Randomized runs checked by the per-cycle model
    for (int r = 0; r < 40; r++) begin
      int tx_mode;
      tx_mode = $urandom_range(0, 2);
      abort = ($urandom_range(0, 9) == 0);
      do_start($urandom_range(0, 1023), $urandom_range(0, 5));
      for (int k = 0; k < 600 && busy; k++) begin
        tx_idle   = (tx_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        abort     = ($urandom_range(0, 59) == 0);
        start     = ($urandom_range(0, 7) == 0);
        base_addr = AW'($urandom_range(0, 1023));
        count     = AW'($urandom_range(0, 5));
        tick();
      end
      start = 1'b0; abort = 1'b0; tx_idle = 1'b1;
      chk("rand_timeout", 32'(busy), 32'd0);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_output_sequencer.md
# accel_output_sequencer

Controller that walks a block of accelerator result words out of the result RAM and feeds them, one at a time, to the output decoder (18-bit word in, four ASCII digits plus CR out). Sits between the accelerator result memory and the decoder's `read_data`/`read_valid` input. Paces each word so the decoder always finishes its print burst, and waits for the UART transmitter to be idle before starting each burst. Clamps out-of-range values so the decoder never emits non-digit characters.

## Interface
- `ADDR_W`, 10, result RAM address width
- `DATA_W`, 18, result word width; matches the decoder input
- `GAP`, 6, idle cycles after each `read_valid` pulse; legal range 6..255
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a run; ignored unless in IDLE
- `abort`  in  1  synchronous; ends a run without `done`
- `base_addr`  in  ADDR_W  first RAM address; sampled with `start`
- `count`  in  ADDR_W  number of words; sampled with `start`
- `mem_en`  out  1  RAM read enable
- `mem_addr`  out  ADDR_W  RAM read address
- `mem_data`  in  DATA_W  RAM read data, valid the cycle after `mem_en`
- `tx_idle`  in  1  UART transmitter idle
- `read_data`  out  DATA_W  word to decoder
- `read_valid`  out  1  one-cycle strobe to decoder
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at normal end of a run
- `sat`  out  1  sticky: some word in this run was clamped; cleared on accepted `start`

## Operation
- States: IDLE, FETCH, CAPTURE, WAIT_TX, ISSUE, GAP, DONE.
- IDLE: on `start`, latch `base_addr` into the address register and `count` into the remaining counter, and clear `sat`. Go to DONE if `count`==0, else go to FETCH.
- FETCH: `mem_en`=1 and `mem_addr`=current address for exactly one cycle → CAPTURE.
- CAPTURE: latch `mem_data`. If value > 9999, store 9999 and set `sat`. Increment the address modulo 2^ADDR_W and decrement remaining. → WAIT_TX.
- WAIT_TX: stay while `tx_idle`=0. When `tx_idle`=1 → ISSUE.
- ISSUE: `read_valid`=1 for one cycle with `read_data` = latched word → GAP.
- GAP: count exactly GAP cycles. Then go to DONE if remaining==0, else go to FETCH.
- DONE: `done`=1 for one cycle → IDLE.
- `abort` in any non-IDLE state forces IDLE on the next edge. In that case `done` stays 0, `read_valid` and `mem_en` go to 0, and `sat` keeps its value.
- `abort` and `start` both high in IDLE: `abort` wins and `start` is dropped.
- `start` while `busy`: ignored, with no effect on the run.
- Outside ISSUE, `read_data` holds its last value. `mem_addr` holds its last value outside FETCH.
- Address wrap: base 2^ADDR_W−1 is followed by address 0 with no error.
- `count` is full ADDR_W width, so at most 2^ADDR_W−1 words per run.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE and every output is 0: `mem_en`, `mem_addr`, `read_data`, `read_valid`, `busy`, `done`, `sat`. Reset mid-run abandons the run immediately, with no `done`.
- `start` is sampled at the end of cycle 0. Then: FETCH in cycle 1, CAPTURE in cycle 2, WAIT_TX in cycle 3, first `read_valid` in cycle 4 (with `tx_idle`=1).
- Word period with `tx_idle`=1 is GAP+4 cycles (10 by default). Each cycle `tx_idle`=0 in WAIT_TX adds one cycle.
- Spacing between consecutive `read_valid` pulses is always ≥ GAP+4 ≥ 10 cycles. This exceeds the 6 cycles the decoder needs to emit four digits and CR.
- `done` rises GAP+1 cycles after the last `read_valid`. `busy` falls on the cycle after `done`.
- `count`=0: DONE in cycle 1, `busy` high for one cycle only, no `mem_en`, no `read_valid`.

## Test plan
- Normal run: RAM[5..7]=42,1234,9999; `base_addr`=5, `count`=3, `tx_idle`=1, start at cycle 0.
  - `read_valid` at cycles 4, 14, 24 with data 42, 1234, 9999.
  - `done` at cycle 31, `busy` low from cycle 32, `sat`=0.
- Saturation: RAM[0]=12000, `count`=1 → `read_data`=9999 at cycle 4 and `sat`=1. The next `start` clears `sat` to 0.
- Backpressure: hold `tx_idle`=0 from cycle 0 to cycle 22 with `count`=1.
  - FETCH/CAPTURE complete by cycle 2; no `read_valid` during cycles 3–22.
  - `read_valid` at cycle 24 (ISSUE follows the first WAIT_TX cycle with `tx_idle`=1); `done` at cycle 31.
- Wrap and zero count: `base_addr`=1023, `count`=2 → `mem_en` addresses 1023 then 0. Separately, `count`=0 → `done` at cycle 1 with no `mem_en` activity.
- Abort and reset: `count`=4, `abort` during the second GAP → IDLE next cycle, no `done`, no further `read_valid`. Repeat with `rst` low mid-run → all outputs 0 asynchronously, and a fresh `start` runs normally.
- Start while busy: a second `start` at cycle 6 with a different `base_addr` → ignored; data and addresses match the first run exactly.
